// File: rtl/lcd_pkg.sv
// Shared types, HD44780 command constants and the power-on init table for the LCD bus sequencer.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_POWERUP,
        ST_INIT_LOAD,
        ST_SETUP,
        ST_EPULSE,
        ST_HOLD,
        ST_WAIT,
        ST_IDLE
    } lcd_state_t;

    typedef enum logic [1:0] {
        WAIT_LONG,
        WAIT_MID,
        WAIT_CMD,
        WAIT_CLEAR
    } wait_sel_t;

    localparam logic [7:0] CMD_CLEAR        = 8'h01;
    localparam logic [7:0] CMD_HOME         = 8'h02;
    localparam logic [7:0] CMD_FUNC_8BIT    = 8'h30;
    localparam logic [7:0] CMD_FUNC_8BIT_2L = 8'h38;
    localparam logic [7:0] CMD_DISP_ON      = 8'h0C;
    localparam logic [7:0] CMD_ENTRY_INC    = 8'h06;

    localparam logic [2:0] INIT_LAST_IDX = 3'd6;
    // 100 us settle after the second wake-up write; not a tunable bus timing.
    localparam int         INIT_MID_CYC  = 5000;

    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: return CMD_FUNC_8BIT;
            3'd3:             return CMD_FUNC_8BIT_2L;
            3'd4:             return CMD_DISP_ON;
            3'd5:             return CMD_CLEAR;
            3'd6:             return CMD_ENTRY_INC;
            default:          return CMD_FUNC_8BIT;
        endcase
    endfunction

    function automatic wait_sel_t init_wait(input logic [2:0] idx);
        case (idx)
            3'd0:    return WAIT_LONG;
            3'd1:    return WAIT_MID;
            3'd5:    return WAIT_CLEAR;
            default: return WAIT_CMD;
        endcase
    endfunction

    // Clear and home (0x01..0x03 with RS=0) need the long post-write wait.
    function automatic logic is_clear_home(input logic rs, input logic [7:0] data);
        return (rs == 1'b0) && ((data == CMD_CLEAR) || (data == CMD_HOME) || (data == 8'h03));
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_wait_timer.sv
// Shared down-counter: loads a cycle count and flags done while it sits at 1.
module lcd_wait_timer #(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = {CNT_W{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_value,
    output logic             o_done
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;

    // Down-count from the loaded value, parking at 1 (no wrap).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= RST_VAL;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (r_cnt > ONE) begin
            r_cnt <= r_cnt - ONE;
        end
    end

    assign o_done = (r_cnt == ONE);

endmodule

// File: rtl/lcd_bus_sequencer.sv
// HD44780 bus owner: power-on init sequence, then round-robin arbitrated byte writes
// from two requesters, with setup / E-pulse / hold / post-write wait timing.
module lcd_bus_sequencer
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC      = 5,
    parameter int E_PULSE_CYC    = 25,
    parameter int CMD_WAIT_CYC   = 2500,
    parameter int CLEAR_WAIT_CYC = 82000,
    parameter int INIT_LONG_CYC  = 205000,
    parameter int POWERUP_CYC    = 750000
) (
    input  logic        clk_50MHZ,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [1:0]  rs_in,
    input  logic [15:0] data_in,
    output logic [1:0]  ack,
    output logic        init_done,
    output logic        busy,
    output logic        LCD_RS,
    output logic        LCD_RW,
    output logic        LCD_E,
    output logic [7:0]  LCD_DATA
);

    localparam int MAX_CYC = max2(max2(max2(SETUP_CYC, E_PULSE_CYC), max2(CMD_WAIT_CYC, CLEAR_WAIT_CYC)),
                                  max2(max2(INIT_LONG_CYC, POWERUP_CYC), INIT_MID_CYC));
    localparam int CNT_W = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] SETUP_V   = CNT_W'(SETUP_CYC);
    localparam logic [CNT_W-1:0] EPULSE_V  = CNT_W'(E_PULSE_CYC);
    localparam logic [CNT_W-1:0] CMD_V     = CNT_W'(CMD_WAIT_CYC);
    localparam logic [CNT_W-1:0] CLEAR_V   = CNT_W'(CLEAR_WAIT_CYC);
    localparam logic [CNT_W-1:0] LONG_V    = CNT_W'(INIT_LONG_CYC);
    localparam logic [CNT_W-1:0] MID_V     = CNT_W'(INIT_MID_CYC);
    localparam logic [CNT_W-1:0] POWERUP_V = CNT_W'(POWERUP_CYC);

    lcd_state_t r_state;
    logic [2:0] r_idx;
    logic       r_rr;
    logic [1:0] r_ack;
    logic       r_init_done;
    logic       r_busy;
    logic       r_lcd_rs;
    logic       r_lcd_e;
    logic [7:0] r_lcd_data;
    wait_sel_t  r_wait_sel;

    logic             w_done;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic [CNT_W-1:0] w_wait_val;
    logic             w_grant;
    logic             w_winner;
    logic             w_win_rs;
    logic [7:0]       w_win_data;

    // Round-robin pick: the pointer only matters when both requesters are asking.
    always_comb begin
        w_grant  = |req;
        w_winner = req[1];
        if (req == 2'b11) begin
            w_winner = r_rr;
        end else begin
            w_winner = req[1];
        end
        w_win_rs   = rs_in[w_winner];
        w_win_data = w_winner ? data_in[15:8] : data_in[7:0];
    end

    // Post-write wait length for the entry captured in r_wait_sel.
    always_comb begin
        w_wait_val = CMD_V;
        case (r_wait_sel)
            WAIT_LONG:  w_wait_val = LONG_V;
            WAIT_MID:   w_wait_val = MID_V;
            WAIT_CLEAR: w_wait_val = CLEAR_V;
            WAIT_CMD:   w_wait_val = CMD_V;
            default:    w_wait_val = CMD_V;
        endcase
    end

    // Timer reload on every transition into a timed state.
    always_comb begin
        w_load     = 1'b0;
        w_load_val = SETUP_V;
        case (r_state)
            ST_INIT_LOAD: w_load = 1'b1;
            ST_IDLE:      w_load = w_grant;
            ST_SETUP: begin
                w_load     = w_done;
                w_load_val = EPULSE_V;
            end
            ST_EPULSE:    w_load = w_done;
            ST_HOLD: begin
                w_load     = w_done;
                w_load_val = w_wait_val;
            end
            default:      w_load = 1'b0;
        endcase
    end

    lcd_wait_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (POWERUP_V)
    ) u_timer (
        .clk     (clk_50MHZ),
        .rst_n   (reset),
        .i_load  (w_load),
        .i_value (w_load_val),
        .o_done  (w_done)
    );

    // Bus sequencing FSM with registered pin and handshake outputs.
    always_ff @(posedge clk_50MHZ or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_POWERUP;
            r_idx       <= 3'd0;
            r_rr        <= 1'b0;
            r_ack       <= 2'b00;
            r_init_done <= 1'b0;
            r_busy      <= 1'b1;
            r_lcd_rs    <= 1'b0;
            r_lcd_e     <= 1'b0;
            r_lcd_data  <= 8'h00;
            r_wait_sel  <= WAIT_CMD;
        end else begin
            r_ack <= 2'b00;
            case (r_state)
                ST_POWERUP: begin
                    if (w_done) begin
                        r_idx   <= 3'd0;
                        r_state <= ST_INIT_LOAD;
                    end
                end
                ST_INIT_LOAD: begin
                    r_lcd_rs   <= 1'b0;
                    r_lcd_data <= init_cmd(r_idx);
                    r_wait_sel <= init_wait(r_idx);
                    r_state    <= ST_SETUP;
                end
                ST_SETUP: begin
                    if (w_done) begin
                        r_lcd_e <= 1'b1;
                        r_state <= ST_EPULSE;
                    end
                end
                ST_EPULSE: begin
                    if (w_done) begin
                        r_lcd_e <= 1'b0;
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_done) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_done) begin
                        if (r_init_done || (r_idx == INIT_LAST_IDX)) begin
                            r_init_done <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_idx   <= r_idx + 3'd1;
                            r_state <= ST_INIT_LOAD;
                        end
                    end
                end
                ST_IDLE: begin
                    if (w_grant) begin
                        r_ack      <= w_winner ? 2'b10 : 2'b01;
                        r_rr       <= ~w_winner;
                        r_lcd_rs   <= w_win_rs;
                        r_lcd_data <= w_win_data;
                        r_wait_sel <= is_clear_home(w_win_rs, w_win_data) ? WAIT_CLEAR : WAIT_CMD;
                        r_busy     <= 1'b1;
                        r_state    <= ST_SETUP;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                default: begin
                    r_lcd_e <= 1'b0;
                    r_busy  <= 1'b1;
                    r_state <= ST_POWERUP;
                end
            endcase
        end
    end

    assign ack       = r_ack;
    assign init_done = r_init_done;
    assign busy      = r_busy;
    assign LCD_RS    = r_lcd_rs;
    assign LCD_RW    = 1'b0;
    assign LCD_E     = r_lcd_e;
    assign LCD_DATA  = r_lcd_data;

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Directed bench for lcd_bus_sequencer with shortened timing (SETUP 2, E 4, CMD 10, CLEAR 30, LONG 50, PWR 100).
module tb_lcd_bus_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [1:0]  rs_in = 2'b00;
    logic [15:0] data_in = 16'h0000;
    logic [1:0]  ack;
    logic        init_done, busy, LCD_RS, LCD_RW, LCD_E;
    logic [7:0]  LCD_DATA;

    int n_checks = 0;
    int n_fail   = 0;
    logic [8:0] pulse_q[$];

    always #5 clk = ~clk;

    lcd_bus_sequencer #(
        .SETUP_CYC(2), .E_PULSE_CYC(4), .CMD_WAIT_CYC(10),
        .CLEAR_WAIT_CYC(30), .INIT_LONG_CYC(50), .POWERUP_CYC(100)
    ) dut (
        .clk_50MHZ(clk), .reset(rst_n), .req(req), .rs_in(rs_in), .data_in(data_in),
        .ack(ack), .init_done(init_done), .busy(busy), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
        .LCD_E(LCD_E), .LCD_DATA(LCD_DATA)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // E-pulse monitor: width, RS/DATA stability 2 cycles around the pulse, logs each pulse.
    logic [8:0] m_h1 = 9'h000, m_h2 = 9'h000, m_val = 9'h000;
    logic       m_prev_e = 1'b0;
    int         m_high = 0, m_post = 0;
    always @(negedge clk) begin : mon
        logic [8:0] cur;
        cur = {LCD_RS, LCD_DATA};
        if (!rst_n) begin
            m_high = 0;
            m_post = 0;
        end else if (LCD_E && !m_prev_e) begin
            check("setup_rs_data", {31'd0, (m_h1 == cur) && (m_h2 == cur)}, 32'd1);
            m_val  = cur;
            m_high = 1;
        end else if (LCD_E) begin
            m_high++;
            check("pulse_rs_data", {23'd0, cur}, {23'd0, m_val});
        end else if (m_prev_e) begin
            check("e_high_cycles", m_high, 32'd4);
            check("hold_rs_data", {23'd0, cur}, {23'd0, m_val});
            pulse_q.push_back(m_val);
            m_post = 1;
        end else if (m_post == 1) begin
            check("hold_rs_data", {23'd0, cur}, {23'd0, m_val});
            m_post = 0;
        end
        m_h2     = m_h1;
        m_h1     = cur;
        m_prev_e = rst_n ? LCD_E : 1'b0;
    end

    task automatic wait_ack(output logic [1:0] a, output int lat);
        a = 2'b00;
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (ack != 2'b00) begin
                a = ack;
                lat = k;
                break;
            end
        end
    endtask

    task automatic wait_idle(output int n);
        n = -1;
        for (int k = 1; k <= 500; k++) begin
            @(negedge clk);
            if (!busy) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic pop_check(input string name, input logic [8:0] exp);
        logic [8:0] p;
        p = 9'h1FF;
        if (pulse_q.size() > 0) p = pulse_q.pop_front();
        check(name, {23'd0, p}, {23'd0, exp});
    endtask

    // Release must happen on the negedge just before this is called.
    task automatic run_init(input string tag);
        int rise_k, done_k;
        logic early;
        logic [7:0] init_tab[7];
        init_tab = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h0C, 8'h01, 8'h06};
        rise_k = 0;
        done_k = 0;
        early  = 1'b0;
        for (int k = 1; k <= 8000; k++) begin
            @(negedge clk);
            if (LCD_E && rise_k == 0) rise_k = k;
            if (ack != 2'b00 && !init_done) early = 1'b1;
            if (init_done) begin
                done_k = k;
                break;
            end
        end
        check({tag, "_first_e_rise"}, rise_k, 32'd103);
        check({tag, "_init_done_cycle"}, done_k, 32'd5283);
        check({tag, "_no_ack_before_init"}, {31'd0, early}, 32'd0);
        check({tag, "_init_pulse_count"}, pulse_q.size(), 32'd7);
        for (int i = 0; i < 7; i++) pop_check({tag, "_init_pulse"}, {1'b0, init_tab[i]});
    endtask

    typedef struct {
        logic [1:0] req;
        logic       rs;
        logic [7:0] data;
        logic [1:0] exp_ack;
        int         exp_wait;
    } vec_t;

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t vecs[8];
        logic [1:0] a;
        int lat, n;
        logic saw_e;

        vecs[0] = '{2'b01, 1'b0, 8'h01, 2'b01, 30};
        vecs[1] = '{2'b10, 1'b0, 8'h80, 2'b10, 10};
        vecs[2] = '{2'b01, 1'b0, 8'h02, 2'b01, 30};
        vecs[3] = '{2'b10, 1'b0, 8'h03, 2'b10, 30};
        vecs[4] = '{2'b01, 1'b0, 8'h04, 2'b01, 10};
        vecs[5] = '{2'b10, 1'b0, 8'h00, 2'b10, 10};
        vecs[6] = '{2'b01, 1'b1, 8'h01, 2'b01, 10};
        vecs[7] = '{2'b10, 1'b0, 8'h01, 2'b10, 30};

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_lcd_e", {31'd0, LCD_E}, 32'd0);
        check("rst_lcd_rs", {31'd0, LCD_RS}, 32'd0);
        check("rst_lcd_rw", {31'd0, LCD_RW}, 32'd0);
        check("rst_lcd_data", {24'd0, LCD_DATA}, 32'd0);
        check("rst_ack", {30'd0, ack}, 32'd0);
        check("rst_init_done", {31'd0, init_done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd1);

        // Request held through init must wait for init_done.
        req = 2'b01; rs_in = 2'b01; data_in = 16'h0041;
        rst_n = 1'b1;
        run_init("init1");
        wait_ack(a, lat);
        check("pending_ack", {30'd0, a}, 32'd1);
        check("pending_ack_latency", lat, 32'd1);
        req = 2'b00;
        wait_idle(n);
        check("pending_busy_cycles", n, 32'd18);
        pop_check("pending_pulse", 9'h141);

        for (int i = 0; i < 8; i++) begin
            req = vecs[i].req;
            rs_in = {2{vecs[i].rs}};
            data_in = {2{vecs[i].data}};
            wait_ack(a, lat);
            check("vec_ack", {30'd0, a}, {30'd0, vecs[i].exp_ack});
            check("vec_ack_latency", lat, 32'd1);
            req = 2'b00;
            wait_idle(n);
            check("vec_busy_cycles", n, 8 + vecs[i].exp_wait);
            pop_check("vec_pulse", {vecs[i].rs, vecs[i].data});
        end

        // Both requesters held high: grants alternate, starting with req0.
        req = 2'b11; rs_in = 2'b11; data_in = 16'h5251;
        wait_ack(a, lat);
        check("rr_first", {30'd0, a}, 32'd1);
        data_in[7:0] = 8'h53;
        wait_ack(a, lat);
        check("rr_second", {30'd0, a}, 32'd2);
        check("rr_back_to_back_gap", lat, 32'd19);
        wait_ack(a, lat);
        check("rr_third", {30'd0, a}, 32'd1);
        req = 2'b00;
        wait_idle(n);
        pop_check("rr_pulse0", 9'h151);
        pop_check("rr_pulse1", 9'h152);
        pop_check("rr_pulse2", 9'h153);

        // Reset in the middle of an E pulse.
        req = 2'b01; rs_in = 2'b00; data_in = 16'h0045;
        saw_e = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (LCD_E) begin
                saw_e = 1'b1;
                break;
            end
        end
        check("midpulse_e_seen", {31'd0, saw_e}, 32'd1);
        req = 2'b00;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midpulse_rst_e", {31'd0, LCD_E}, 32'd0);
        check("midpulse_rst_init_done", {31'd0, init_done}, 32'd0);
        check("midpulse_rst_busy", {31'd0, busy}, 32'd1);
        check("midpulse_rst_data", {24'd0, LCD_DATA}, 32'd0);
        pulse_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_init("init2");
        check("post_init_queue_empty", pulse_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
